alarm_clock_ctrl: RTL and testbench

//   Controller/sequencer for the mm:ss alarm-clock counter datapath. It divides clk down to a
//   1 Hz tick, drives the mm:ss counter (run/clear), holds a programmable alarm time and runs
//   the alarm state machine (armed/ringing/snooze). Top-level timekeeping block for the clock.

---
 rtl/alarm_clock_pkg.sv | 23 ++
 rtl/alarm_clock_ctrl_mmss_counter.sv | 29 ++
 rtl/alarm_clock_ctrl.sv | 147 ++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the mm:ss alarm clock.
//   state_t        : alarm FSM encoding (IDLE/ARMED/RINGING/SNOOZE)
//   TIME_W/STATE_W : field widths
//   MAX_SEC/MAX_MIN: last legal value of each time field
//   sat()          : clamp a time field to its legal maximum
package alarm_clock_pkg;
  localparam int TIME_W  = 6;
  localparam int STATE_W = 2;
  localparam int MAX_SEC = 59;
  localparam int MAX_MIN = 59;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  function automatic logic [TIME_W-1:0] sat(input logic [TIME_W-1:0] v,
                                            input logic [TIME_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/alarm_clock_ctrl_mmss_counter.sv
// mm:ss time counter with 59:59 -> 00:00 wrap.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   inc       : advance one second
//   clr       : zero both fields (wins over inc)
//   seconds   : 0..59
//   minutes   : 0..59
module mmss_counter import alarm_clock_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [TIME_W-1:0] seconds,
  output logic [TIME_W-1:0] minutes
);
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      seconds <= '0;
      minutes <= '0;
    end else if (inc) begin
      if (seconds == TIME_W'(MAX_SEC)) begin
        seconds <= '0;
        minutes <= (minutes == TIME_W'(MAX_MIN)) ? '0 : minutes + TIME_W'(1);
      end else begin
        seconds <= seconds + TIME_W'(1);
      end
    end
  end
endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock controller: 1 Hz prescaler, mm:ss counter, alarm register,
// match compare and alarm FSM with ring/snooze timers.
// Optional feature macro: SNOOZE_EN (enables the snooze input and SNOOZE state).
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   run_en              : advance prescaler/time; 0 freezes time and timers
//   clr                 : zero time and prescaler
//   set_alarm           : capture alarm_min/alarm_sec (saturated to 59)
//   alarm_on            : alarm enable level; 0 forces IDLE
//   stop, snooze        : dismiss / snooze pulses
//   seconds, minutes    : current time
//   tick                : one-cycle pulse, high in the cycle the new time appears
//   ringing, state      : FSM outputs
module alarm_clock_ctrl import alarm_clock_pkg::*; #(
  parameter int TICK_DIV    = 100,
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  input  logic               clr,
  input  logic               set_alarm,
  input  logic [TIME_W-1:0]  alarm_min,
  input  logic [TIME_W-1:0]  alarm_sec,
  input  logic               alarm_on,
  input  logic               stop,
  input  logic               snooze,
  output logic [TIME_W-1:0]  seconds,
  output logic [TIME_W-1:0]  minutes,
  output logic               tick,
  output logic               ringing,
  output logic [STATE_W-1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(RING_SECS + 1);

  logic [PW-1:0]     pre;
  logic              wrap, tick_r;
  logic [TIME_W-1:0] al_min, al_sec;
  logic              match, ring_done;
  logic [RW-1:0]     ring_tmr;
  state_t            state_q, state_nx;

  // Prescaler; wrap marks the edge on which the time advances.
  assign wrap = run_en && (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      pre    <= '0;
      tick_r <= 1'b0;
    end else begin
      tick_r <= wrap;
      if (run_en) pre <= wrap ? '0 : pre + PW'(1);
    end
  end

  mmss_counter u_mmss (
    .clk     (clk),
    .rst     (rst),
    .inc     (wrap),
    .clr     (clr),
    .seconds (seconds),
    .minutes (minutes)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      al_min <= '0;
      al_sec <= '0;
    end else if (set_alarm) begin
      al_min <= sat(alarm_min, TIME_W'(MAX_MIN));
      al_sec <= sat(alarm_sec, TIME_W'(MAX_SEC));
    end
  end

  // Gating on tick_r means only a real time advance can fire the alarm,
  // never a clr or an alarm write that happens to equal the current time.
  assign match     = tick_r && (seconds == al_sec) && (minutes == al_min);
  assign ring_done = tick_r && (ring_tmr <= RW'(1));

`ifdef SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  logic [SW-1:0] snz_tmr;
  logic          snz_done;
  assign snz_done = tick_r && (snz_tmr <= SW'(1));

  always_ff @(posedge clk) begin
    if (!rst)
      snz_tmr <= '0;
    else if (state_nx == SNOOZE && state_q != SNOOZE)
      snz_tmr <= SW'(SNOOZE_SECS);
    else if (state_q == SNOOZE && tick_r && snz_tmr != '0)
      snz_tmr <= snz_tmr - SW'(1);
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ SNOOZE_SECS[0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    if (!alarm_on) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_nx = ARMED;
        ARMED:   if (!stop && match) state_nx = RINGING;
        RINGING: begin
          if (stop)           state_nx = ARMED;
`ifdef SNOOZE_EN
          else if (snooze)    state_nx = SNOOZE;
`endif
          else if (ring_done) state_nx = ARMED;
        end
`ifdef SNOOZE_EN
        SNOOZE: begin
          if (stop)          state_nx = ARMED;
          else if (snz_done) state_nx = RINGING;
        end
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  // Ring timer reloads on every entry to RINGING (first ring and re-ring).
  always_ff @(posedge clk) begin
    if (!rst)
      ring_tmr <= '0;
    else if (state_nx == RINGING && state_q != RINGING)
      ring_tmr <= RW'(RING_SECS);
    else if (state_q == RINGING && tick_r && ring_tmr != '0)
      ring_tmr <= ring_tmr - RW'(1);
  end

  always_comb begin
    ringing = (state_q == RINGING);
    state   = state_q;
    tick    = tick_r;
  end
endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Testbench for alarm_clock_ctrl (TICK_DIV=4, RING_SECS=3, SNOOZE_SECS=2).
// Works with and without SNOOZE_EN defined.
module tb_alarm_clock_ctrl;
  logic       clk = 1'b0, rst = 1'b0, run_en = 1'b0, clr = 1'b0, set_alarm = 1'b0;
  logic       alarm_on = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [5:0] alarm_min = '0, alarm_sec = '0;
  logic [5:0] seconds, minutes;
  logic       tick, ringing;
  logic [1:0] state;
  int errors = 0, checks = 0;

`ifdef SNOOZE_EN
  localparam int SNZ_ST = 3, END_SEC = 7;
`else
  localparam int SNZ_ST = 2, END_SEC = 5;
`endif

  alarm_clock_ctrl #(.TICK_DIV(4), .RING_SECS(3), .SNOOZE_SECS(2)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .clr(clr), .set_alarm(set_alarm),
    .alarm_min(alarm_min), .alarm_sec(alarm_sec), .alarm_on(alarm_on),
    .stop(stop), .snooze(snooze), .seconds(seconds), .minutes(minutes),
    .tick(tick), .ringing(ringing), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic run_en, clr, alarm_on;
    int   sec, min;
    logic tck;
    int   st;
  } vec_t;
  vec_t tbl[19];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_tick: got no tick expected one within 12 cycles");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic do_reset();
    rst = 1'b0; run_en = 1'b0; clr = 1'b0; set_alarm = 1'b0;
    alarm_on = 1'b0; stop = 1'b0; snooze = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic pulse_alarm(input int m, input int s);
    set_alarm = 1'b1; alarm_min = 6'(m); alarm_sec = 6'(s);
    step();
    set_alarm = 1'b0;
  endtask

  task automatic start_ringing(input int s);
    do_reset();
    run_en = 1'b1; alarm_on = 1'b1;
    pulse_alarm(0, s);
    for (int i = 0; i < s; i++) wait_tick();
    step();
  endtask

  initial begin
    // run, clr, on | sec, min, tick, state
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 1};
    tbl[1]  = '{1, 0, 1, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 1, 0, 0, 0, 1};
    tbl[3]  = '{1, 0, 1, 1, 0, 1, 1};
    tbl[4]  = '{1, 0, 1, 1, 0, 0, 1};
    tbl[5]  = '{1, 0, 1, 1, 0, 0, 1};
    tbl[6]  = '{1, 0, 1, 1, 0, 0, 1};
    tbl[7]  = '{1, 0, 1, 2, 0, 1, 1};
    tbl[8]  = '{1, 0, 1, 2, 0, 0, 1};
    tbl[9]  = '{1, 0, 1, 2, 0, 0, 1};
    tbl[10] = '{1, 0, 1, 2, 0, 0, 1};
    tbl[11] = '{1, 1, 1, 0, 0, 0, 1};  // clr on the tick edge: no tick, no fire at 00:00
    tbl[12] = '{1, 0, 1, 0, 0, 0, 1};
    tbl[13] = '{1, 0, 1, 0, 0, 0, 1};
    tbl[14] = '{1, 0, 1, 0, 0, 0, 1};
    tbl[15] = '{1, 0, 1, 1, 0, 1, 1};
    tbl[16] = '{0, 0, 1, 1, 0, 0, 1};
    tbl[17] = '{0, 0, 1, 1, 0, 0, 1};
    tbl[18] = '{1, 0, 1, 1, 0, 0, 1};

    // Reset state
    do_reset();
    chk("rst_sec", seconds, 0);
    chk("rst_min", minutes, 0);
    chk("rst_tick", tick, 0);
    chk("rst_state", state, 0);
    chk("rst_ringing", ringing, 0);

    // Table: counting, clr-vs-tick, run_en freeze
    foreach (tbl[i]) begin
      run_en = tbl[i].run_en; clr = tbl[i].clr; alarm_on = tbl[i].alarm_on;
      step();
      chk($sformatf("row%0d_sec", i), seconds, tbl[i].sec);
      chk($sformatf("row%0d_min", i), minutes, tbl[i].min);
      chk($sformatf("row%0d_tick", i), tick, tbl[i].tck);
      chk($sformatf("row%0d_state", i), state, tbl[i].st);
      chk($sformatf("row%0d_ringing", i), ringing, int'(tbl[i].st == 2));
    end
    clr = 1'b0;

    // Alarm fire at 00:05 and auto-return after 3 ticks
    do_reset();
    run_en = 1'b1; alarm_on = 1'b1;
    pulse_alarm(0, 5);
    chk("fire_armed", state, 1);
    for (int i = 0; i < 5; i++) wait_tick();
    chk("fire_sec", seconds, 5);
    chk("fire_pre_ring", ringing, 0);
    step();
    chk("fire_ringing", ringing, 1);
    chk("fire_state", state, 2);
    for (int s = 6; s <= 8; s++) begin
      wait_tick();
      chk($sformatf("fire_hold_sec%0d", s), state, 2);
    end
    chk("fire_end_sec", seconds, 8);
    step();
    chk("fire_timeout_state", state, 1);
    chk("fire_timeout_ringing", ringing, 0);

    // stop beats snooze; alarm_on=0 forces IDLE
    start_ringing(2);
    chk("stop_pre_state", state, 2);
    stop = 1'b1; snooze = 1'b1;
    step();
    stop = 1'b0; snooze = 1'b0;
    chk("stop_state", state, 1);
    pulse_alarm(0, 4);
    wait_tick(); wait_tick();
    chk("refire_sec", seconds, 4);
    step();
    chk("refire_state", state, 2);
    alarm_on = 1'b0;
    step();
    chk("off_state", state, 0);
    chk("off_ringing", ringing, 0);

    // Snooze (or ignored snooze) then run_en freeze while ringing
    start_ringing(2);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snz_state", state, SNZ_ST);
    wait_tick();
    chk("snz_tick3_state", state, SNZ_ST);
    wait_tick();
    chk("snz_tick4_state", state, SNZ_ST);
    step();
    chk("snz_rering_state", state, 2);
    run_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("frz%0d_sec", i), seconds, 4);
      chk($sformatf("frz%0d_ringing", i), ringing, 1);
    end
    run_en = 1'b1;
    for (int s = 5; s <= END_SEC; s++) begin
      wait_tick();
      chk($sformatf("resume_sec%0d_state", s), state, 2);
    end
    chk("resume_end_sec", seconds, END_SEC);
    step();
    chk("resume_done_state", state, 1);

    // set_alarm equal to current time never fires without a matching tick
    do_reset();
    run_en = 1'b1; alarm_on = 1'b1;
    step();
    for (int i = 0; i < 3; i++) wait_tick();
    chk("static_sec", seconds, 3);
    pulse_alarm(0, 3);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("static%0d_state", i), state, 1);
    end
    chk("static_end_sec", seconds, 4);

    // Saturating alarm 63:63 -> 59:59, full wrap, reset mid-ring
    do_reset();
    run_en = 1'b1; alarm_on = 1'b1;
    pulse_alarm(63, 63);
    for (int n = 1; n <= 3600; n++) begin
      wait_tick();
      if (n == 59) begin
        chk("wrap59_sec", seconds, 59);
        chk("wrap59_min", minutes, 0);
      end else if (n == 60) begin
        chk("wrap60_sec", seconds, 0);
        chk("wrap60_min", minutes, 1);
      end else if (n == 3599) begin
        chk("wrap3599_sec", seconds, 59);
        chk("wrap3599_min", minutes, 59);
        chk("wrap3599_state", state, 1);
      end else if (n == 3600) begin
        chk("wrap3600_sec", seconds, 0);
        chk("wrap3600_min", minutes, 0);
        chk("sat_ring_state", state, 2);
      end
    end
    rst = 1'b0;
    step();
    chk("rst_abort_state", state, 0);
    chk("rst_abort_ringing", ringing, 0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
